// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial NOR-gate subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_nor_cell.sv
// Full-subtractor cell built only from 2-input NOR gates: d = x^y^bin, bo = ~x&y | ~(x^y)&bin.
module fs_nor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic n1, nxy, xny, xnor_xy;
    logic m1, m2, m3;
    logic nbin, nxnor, t, nbo;

    // XNOR(x,y) from four NORs; the intermediate nxy = ~x&y is reused for the borrow term
    nor g1 (n1, x, y);
    nor g2 (nxy, x, n1);
    nor g3 (xny, y, n1);
    nor g4 (xnor_xy, nxy, xny);

    // d = XNOR(XNOR(x,y), bin) = x^y^bin
    nor g5 (m1, xnor_xy, bin);
    nor g6 (m2, xnor_xy, m1);
    nor g7 (m3, bin, m1);
    nor g8 (d, m2, m3);

    // t = XNOR(x,y) & bin, then bo = nxy | t
    nor g9  (nbin, bin, bin);
    nor g10 (nxnor, xnor_xy, xnor_xy);
    nor g11 (t, nbin, nxnor);
    nor g12 (nbo, nxy, t);
    nor g13 (bo, nbo, nbo);

endmodule

// File: rtl/serial_sub_nor.sv
// Bit-serial WIDTH-bit subtractor diff = a - b, LSB first, one NOR-cell step per clock.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_sub_nor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       state_dbg
);

    // Handshake: start is taken only while busy=0 (IDLE); busy stays high until the
    // edge after the single-cycle done pulse, and diff/borrow_out are final during done.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;

    fs_nor_cell u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .bin (brw),
        .d   (d),
        .bo  (bo)
    );

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        diff  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    diff <= {d, diff[WIDTH-1:1]};
                    brw  <= bo;
                    if (cnt == LAST) begin
                        // Final step: a_sh[0]/b_sh[0] now hold the operand MSBs
                        state      <= DONE;
                        done       <= 1'b1;
                        borrow_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (a_sh[0] != b_sh[0]) && (d != a_sh[0]);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nor.sv
// Self-checking bench for serial_sub_nor: directed vectors, expected-queue scoreboard, done monitor.
module tb_serial_sub_nor;
    import serial_sub_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic [1:0]       state_dbg;
    logic             act_ovf;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    assign act_ovf = ovf;
`else
    assign act_ovf = 1'b0;
`endif

    serial_sub_nor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUB_OVF_EN
        .ovf        (ovf),
`endif
        .state_dbg  (state_dbg)
    );

    logic cx, cy, cbin, cd, cbo;
    fs_nor_cell u_cell_tb (.x(cx), .y(cy), .bin(cbin), .d(cd), .bo(cbo));

    // clock/reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard state
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [WIDTH+1:0] exp_q[$];
    int acc_q[$];
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [WIDTH+1:0] e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e[WIDTH-1:0]));
                check("borrow_out", 32'(borrow_out), 32'(e[WIDTH]));
                check("ovf", 32'(act_ovf), 32'(e[WIDTH+1]));
                check("busy_in_done", 32'(busy), 32'd1);
                if (acc_q.size() != 0) begin
                    int acc;
                    acc = acc_q.pop_front();
                    check("done_latency", 32'(cyc - acc), 32'(WIDTH));
                end
            end
        end
        prev_done = done;
    end

    // driver tasks
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [WIDTH+1:0] pack_exp(input logic [WIDTH-1:0] ed, input logic eb,
                                                  input logic eo);
`ifdef SERIAL_SUB_OVF_EN
        return {eo, eb, ed};
`else
        return {1'b0 & eo, eb, ed};
`endif
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                          input bit push);
        wait_idle();
        a = va;
        b = vb;
        start = 1'b1;
        if (push) exp_q.push_back(pack_exp(ed, eb, eo));
        @(posedge clk);
        #1;
        if (push) acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_borrow"}, 32'(borrow_out), 32'd0);
        check({tag, "_ovf"}, 32'(act_ovf), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    logic [7:0] d_tt;
    logic [7:0] bo_tt;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        // truth table indexed by {x,y,bin}
        d_tt  = 8'b1001_0110;
        bo_tt = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            {cx, cy, cbin} = idx;
            #1;
            check("cell_d", 32'(cd), 32'(d_tt[idx]));
            check("cell_bo", 32'(cbo), 32'(bo_tt[idx]));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b1);
        run_op(8'd5,   8'd9,  8'hFC, 1'b1, 1'b0, 1'b1);
        run_op(8'h80,  8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
        run_op(8'h7F,  8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
        run_op(8'hAA,  8'h55, 8'h55, 1'b0, 1'b1, 1'b1);
        run_op(8'h00,  8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);

        // start held high through the whole operation: exactly one accept, then a second at IDLE
        wait_idle();
        a = 8'd20;
        b = 8'd3;
        start = 1'b1;
        exp_q.push_back(pack_exp(8'd17, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        @(negedge clk);
        a = 8'd1;
        b = 8'd1;
        exp_q.push_back(pack_exp(8'd0, 1'b0, 1'b0));
        wait_idle();
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;

        // reset in the middle of SHIFT: no done pulse, outputs back to reset values
        run_op(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        rst = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);

        wait_idle();
        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
